barrel_unrotate_seq: RTL
========================

// Module: barrel_unrotate_seq
// PURPOSE
//   Sequential inverse of the combinational barrel rotator. Two ops:
//   - UNDO: restores the original word from a rotated word, given the
//     rotation that was applied.
//   - SEARCH: finds the right-rotation amount that maps a word onto a
//     known alignment pattern.
//   Processes one bit position per clock. Uses a valid/ready handshake on
//   both input and output. Sits on the receive side of the rotator datapath.
// PARAMETERS
//   WIDTH  8  data width; power of two, >=2; MAG_W = $clog2(WIDTH) (localparam)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      block can accept a request (high only in IDLE)
//   in_op      in   1      0 = UNDO, 1 = SEARCH
//   in_ctrl    in   1      UNDO: direction originally applied (0 = right, 1 = left)
//   in_mag     in   MAG_W  UNDO: rotation amount originally applied
//   in_data    in   WIDTH  rotated word (UNDO) or raw word (SEARCH)
//   in_pattern in   WIDTH  SEARCH: alignment target
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  WIDTH  restored word (UNDO) / aligned word (SEARCH)
//   out_mag    out  MAG_W  SEARCH: right-rotation amount found; UNDO: echoes in_mag
//   out_found  out  1      SEARCH: match found; UNDO: always 1
// BEHAVIOUR
//   - Clock and reset: single clock domain. rst_n low clears all state
//     immediately, including mid-operation. State -> IDLE, in_ready=1,
//     out_valid=0, out_data=0, out_mag=0, out_found=0, internal counter=0.
//   - States: IDLE, RUN, DONE. All outputs are registered.
//   - IDLE: in_ready=1. On in_valid&in_ready, capture op/ctrl/mag/data/pattern
//     and go to RUN. UNDO: cnt=in_mag. SEARCH: k=0.
//   - UNDO in RUN, each cycle:
//     - if cnt!=0: rotate the word 1 bit opposite to in_ctrl (ctrl=0 -> left,
//       ctrl=1 -> right) and decrement cnt;
//     - if cnt==0: go to DONE.
//     - out_valid asserts mag+1 cycles after the accept edge.
//     - mag=0 returns in_data unchanged after 1 cycle.
//   - SEARCH in RUN, each cycle, compare word to pattern:
//     - match: go to DONE with found=1, out_mag=k;
//     - else if k==WIDTH-1: go to DONE with found=0, out_mag=0,
//       out_data=original in_data;
//     - else: rotate word right 1 bit, k=k+1.
//     - The smallest matching k wins. Latency is k+1 cycles; WIDTH cycles
//       when there is no match.
//     - Rotate-right semantics: rotr(x,1) = {x[0], x[WIDTH-1:1]}.
//   - DONE: out_valid=1. out_data, out_mag and out_found stay stable until
//     out_ready. On out_valid&out_ready: out_valid=0 on the next edge and the
//     state returns to IDLE. in_ready is high again from that same edge.
//   - in_valid is ignored outside IDLE. No request overlap; throughput is
//     one request per (latency+2) cycles.
//   - k and cnt wrap-free: MAG_W bits suffice because the maximum value is
//     WIDTH-1.
// TESTING (WIDTH=8)
//   1. UNDO ctrl=0 mag=3 data=0x96 -> out_data=0xB4, found=1, out_mag=3;
//      out_valid 4 cycles after accept.
//   2. UNDO ctrl=1 mag=1 data=0x03 -> 0x81 after 2 cycles.
//      UNDO mag=0 data=0x5A -> 0x5A after 1 cycle.
//   3. SEARCH data=0xB4 pattern=0x96 -> found=1, out_mag=3, out_data=0x96,
//      4 cycles. SEARCH data=0xFF pattern=0xFF -> mag=0, 1 cycle.
//   4. SEARCH data=0x01 pattern=0x03 -> found=0, out_mag=0, out_data=0x01,
//      8 cycles.
//   5. Hold out_ready=0 for 5 cycles in DONE, pulse in_valid meanwhile ->
//      out_* stable, in_ready=0, extra request ignored. Release -> IDLE and
//      in_ready=1 next edge.
//   6. UNDO mag=7, drop rst_n in 3rd RUN cycle -> in_ready=1, out_valid=0
//      immediately. A following UNDO ctrl=1 mag=2 data=0x0C -> 0x03 correct.

Source files
------------

// File: rtl/barrel_unrotate_seq.sv
// rtl/barrel_unrotate_seq.sv - sequential un-rotator / rotation-amount search, one bit per clock
module barrel_unrotate_seq #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_op,
    input  logic                       in_ctrl,
    input  logic [$clog2(WIDTH)-1:0]   in_mag,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [WIDTH-1:0]           in_pattern,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH)-1:0]   out_mag,
    output logic                       out_found
);

    localparam int MAG_W = $clog2(WIDTH);
    localparam logic [MAG_W-1:0] K_LAST = MAG_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic               ctrl_q, ctrl_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    // cnt_q is the remaining rotation count for UNDO and the trial amount k for SEARCH
    logic [MAG_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [WIDTH-1:0]   orig_q, orig_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [MAG_W-1:0]   out_mag_q, out_mag_d;
    logic               out_found_q, out_found_d;

    logic [WIDTH-1:0]   word_rotl;
    logic [WIDTH-1:0]   word_rotr;

    assign word_rotl = {word_q[WIDTH-2:0], word_q[WIDTH-1]};
    assign word_rotr = {word_q[0], word_q[WIDTH-1:1]};

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mag   = out_mag_q;
    assign out_found = out_found_q;

    // Next-state logic: capture in IDLE, step one bit per cycle in RUN, hold results in DONE
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ctrl_d      = ctrl_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        pat_d       = pat_q;
        orig_d      = orig_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mag_d   = out_mag_q;
        out_found_d = out_found_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d       = in_op;
                    ctrl_d     = in_ctrl;
                    mag_d      = in_mag;
                    word_d     = in_data;
                    orig_d     = in_data;
                    pat_d      = in_pattern;
                    cnt_d      = in_op ? '0 : in_mag;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!op_q) begin
                    // Undo by rotating opposite to the originally applied direction
                    if (cnt_q != '0) begin
                        word_d = ctrl_q ? word_rotr : word_rotl;
                        cnt_d  = cnt_q - MAG_W'(1);
                    end else begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = word_q;
                        out_mag_d   = mag_q;
                        out_found_d = 1'b1;
                    end
                end else begin
                    // Testing k in increasing order makes the smallest match win
                    if (word_q == pat_q) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = word_q;
                        out_mag_d   = cnt_q;
                        out_found_d = 1'b1;
                    end else if (cnt_q == K_LAST) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = orig_q;
                        out_mag_d   = '0;
                        out_found_d = 1'b0;
                    end else begin
                        word_d = word_rotr;
                        cnt_d  = cnt_q + MAG_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            ctrl_q      <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            pat_q       <= '0;
            orig_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mag_q   <= '0;
            out_found_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ctrl_q      <= ctrl_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            pat_q       <= pat_d;
            orig_q      <= orig_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mag_q   <= out_mag_d;
            out_found_q <= out_found_d;
        end
    end

endmodule
